// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared types and constants for the motion command sequencer
package motion_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [7:0] ctype;
    logic [7:0] arg1;
    logic [7:0] arg2;
  } cmd_t;

  localparam logic [7:0] CMD_LINE    = 8'd1;
  localparam logic [3:0] RUN_NUM_DEF = 4'd5;
  localparam int         RATIO       = 62;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with level output and flush
module cmd_fifo
  import motion_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  cmd_t                     wdata_i,
  output cmd_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Flush shares the reset path so an abort empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/motion_cmd_sequencer.sv
// rtl/motion_cmd_sequencer.sv - queues motion commands and runs them on the pulse generator
module motion_cmd_sequencer
  import motion_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         CLR_CYCLES  = 2,
  parameter int         WDOG_CYCLES = 0,
  parameter logic [3:0] RUN_NUM     = RUN_NUM_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_type,
  input  logic [7:0]                    cmd_arg1,
  input  logic [7:0]                    cmd_arg2,
  input  logic                          estop,
  input  logic                          clr_fault,
  input  logic                          gen_stop,
  output logic                          gen_rst,
  output logic [7:0]                    gen_para1,
  output logic [7:0]                    gen_para2,
  output logic [7:0]                    gen_para3,
  output logic [3:0]                    gen_data_num,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          cmd_done,
  output logic                          err_type,
  output logic                          timeout
);

  localparam int              CW        = $clog2(CLR_CYCLES + 1);
  localparam logic [CW-1:0]   CLR_LAST  = CW'(CLR_CYCLES - 1);
  localparam logic [31:0]     WDOG_LAST = 32'(WDOG_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]   wdog_q, wdog_d;
  logic          gen_rst_q, gen_rst_d;
  logic [3:0]    data_num_q, data_num_d;
  logic [7:0]    para1_q, para2_q, para3_q;
  logic          estop_l_q, estop_l_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  cmd_t          head, wcmd;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          accept, legal, wd_abort, abort;

  assign cmd_ready = !fifo_full && !estop_l_q;
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = (cmd_type == CMD_LINE);
  assign wcmd      = {cmd_type, cmd_arg1, cmd_arg2};
  assign wd_abort  = (WDOG_CYCLES != 0) && (state_q == S_RUN) && (wdog_q == WDOG_LAST);
  assign abort     = estop || wd_abort;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept && legal),
    .pop_i   (fifo_pop),
    .flush_i (abort),
    .wdata_i (wcmd),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wdog_d    = wdog_q;
    fifo_pop  = 1'b0;
    case (state_q)
      S_IDLE:  if (!fifo_empty && !estop_l_q) state_d = S_LOAD;
      S_LOAD: begin
        fifo_pop  = 1'b1;
        clr_cnt_d = '0;
        state_d   = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          wdog_d  = '0;
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        wdog_d = wdog_q + 32'd1;
        if (gen_stop) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks a gen_stop in the same cycle, so no cmd_done follows.
    if (abort) begin
      state_d  = S_IDLE;
      fifo_pop = 1'b0;
    end

    gen_rst_d  = (state_d != S_RUN);
    data_num_d = (state_d == S_RUN) ? RUN_NUM : 4'd0;
    estop_l_d  = abort ? 1'b1 : (clr_fault ? 1'b0 : estop_l_q);
    timeout_d  = wd_abort ? 1'b1 : (clr_fault ? 1'b0 : timeout_q);
    err_d      = (accept && !legal) ? 1'b1 : (clr_fault ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      wdog_q     <= '0;
      gen_rst_q  <= 1'b1;
      data_num_q <= 4'd0;
      para1_q    <= 8'd0;
      para2_q    <= 8'd0;
      para3_q    <= 8'd0;
      estop_l_q  <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wdog_q     <= wdog_d;
      gen_rst_q  <= gen_rst_d;
      data_num_q <= data_num_d;
      estop_l_q  <= estop_l_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      if (state_q == S_LOAD) begin
        para1_q <= head.ctype;
        para2_q <= head.arg1;
        para3_q <= head.arg2;
      end
    end
  end

  assign gen_rst      = gen_rst_q;
  assign gen_data_num = data_num_q;
  assign gen_para1    = para1_q;
  assign gen_para2    = para2_q;
  assign gen_para3    = para3_q;
  assign busy         = (state_q != S_IDLE);
  assign cmd_done     = (state_q == S_DONE);
  assign err_type     = err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// tb/tb_motion_cmd_sequencer.sv - scoreboard bench for motion_cmd_sequencer
module tb_motion_cmd_sequencer;
  import motion_pkg::*;

  localparam int CLR = 2;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, estop, clr_fault, gen_stop;
  logic [7:0] cmd_type, cmd_arg1, cmd_arg2;
  logic       cmd_ready, gen_rst, busy, cmd_done, err_type, timeout;
  logic [7:0] gen_para1, gen_para2, gen_para3;
  logic [3:0] gen_data_num;
  logic [2:0] fifo_level;

  int   vectors = 0;
  int   miscompares = 0;
  cmd_t exp_q[$];

  motion_cmd_sequencer #(
    .FIFO_DEPTH(4), .CLR_CYCLES(CLR), .WDOG_CYCLES(100), .RUN_NUM(4'd5)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
    .estop(estop), .clr_fault(clr_fault), .gen_stop(gen_stop),
    .gen_rst(gen_rst), .gen_para1(gen_para1), .gen_para2(gen_para2),
    .gen_para3(gen_para3), .gen_data_num(gen_data_num), .busy(busy),
    .fifo_level(fifo_level), .cmd_done(cmd_done), .err_type(err_type),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cmd_done must match the oldest outstanding command.
  always @(negedge clk) begin
    if (!rst && cmd_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_done: got cmd_done=1 expected no pending command at %0t", $time);
      end else begin
        cmd_t e;
        e = exp_q.pop_front();
        if ({gen_para1, gen_para2, gen_para3} !== e) begin
          miscompares++;
          $display("FAIL sb_params: got %h expected %h at %0t",
                   {gen_para1, gen_para2, gen_para3}, e, $time);
        end
      end
    end
  end

  task automatic push_cmd(input logic [7:0] ty, input logic [7:0] a1, input logic [7:0] a2);
    cmd_valid = 1'b1; cmd_type = ty; cmd_arg1 = a1; cmd_arg2 = a2;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    if (cmd_ready !== 1'b1) begin
      chk("push_ready_timeout", 32'(cmd_ready), 32'd1);
    end else if (ty == CMD_LINE) begin
      exp_q.push_back({ty, a1, a2});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (gen_rst === 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (gen_rst !== 1'b0) chk("wait_run_timeout", 32'(gen_rst), 32'd0);
  endtask

  task automatic finish_run(input int stop_after);
    repeat (stop_after) @(negedge clk);
    gen_stop = 1'b1;
    @(negedge clk);
    gen_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gen_rst"}, 32'(gen_rst), 32'd1);
    chk({tag, "_paras"}, 32'({gen_para1, gen_para2, gen_para3}), 32'd0);
    chk({tag, "_data_num"}, 32'(gen_data_num), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_cmd_done"}, 32'(cmd_done), 32'd0);
    chk({tag, "_err_type"}, 32'(err_type), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; estop = 1'b0; clr_fault = 1'b0; gen_stop = 1'b0;
    cmd_type = 8'd0; cmd_arg1 = 8'd0; cmd_arg2 = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single command, exact latency
    push_cmd(8'd1, 8'd10, 8'd20);
    chk("t1_level_t1", 32'(fifo_level), 32'd1);
    chk("t1_busy_t1", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_load_t2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_level_t3", 32'(fifo_level), 32'd0);
    chk("t1_params", 32'({gen_para1, gen_para2, gen_para3}), 32'h010a14);
    chk("t1_clr_t3", 32'(gen_rst), 32'd1);
    @(negedge clk);
    chk("t1_clr_t4", 32'(gen_rst), 32'd1);
    @(negedge clk);
    chk("t1_run_rst_t5", 32'(gen_rst), 32'd0);
    chk("t1_run_num_t5", 32'(gen_data_num), 32'd5);
    finish_run(0);
    chk("t1_done_busy", 32'(busy), 32'd1);
    chk("t1_done_gen_rst", 32'(gen_rst), 32'd1);
    chk("t1_done_num", 32'(gen_data_num), 32'd0);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_done", 32'(cmd_done), 32'd0);

    // 2: burst of five, FIFO fills to depth
    for (int i = 0; i < 5; i++) push_cmd(8'd1, 8'(30 + i), 8'(40 + i));
    chk("t2_ready_full", 32'(cmd_ready), 32'd0);
    chk("t2_level_full", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 5; i++) begin
      wait_run(n);
      if (i > 0) chk("t2_gap", 32'(n - 1), 32'(CLR + 2));
      chk("t2_run_num", 32'(gen_data_num), 32'd5);
      finish_run(i % 3);
    end
    @(negedge clk);
    chk("t2_idle", 32'(busy), 32'd0);

    // 3: illegal type consumed, no run
    push_cmd(8'd3, 8'd1, 8'd2);
    chk("t3_err", 32'(err_type), 32'd1);
    chk("t3_level", 32'(fifo_level), 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_no_run_busy", 32'(busy), 32'd0);
    chk("t3_no_run_rst", 32'(gen_rst), 32'd1);
    pulse_clr();
    chk("t3_err_clr", 32'(err_type), 32'd0);

    // 4: estop mid-RUN with two queued
    push_cmd(8'd1, 8'd50, 8'd51);
    push_cmd(8'd1, 8'd52, 8'd53);
    push_cmd(8'd1, 8'd54, 8'd55);
    wait_run(n);
    chk("t4_level_run", 32'(fifo_level), 32'd2);
    estop = 1'b1;
    exp_q.delete();
    @(negedge clk);
    estop = 1'b0;
    chk("t4_gen_rst", 32'(gen_rst), 32'd1);
    chk("t4_num", 32'(gen_data_num), 32'd0);
    chk("t4_flush", 32'(fifo_level), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready_blk", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_type = 8'd1;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_push_blocked", 32'(fifo_level), 32'd0);
    estop = 1'b1;
    clr_fault = 1'b1;
    @(negedge clk);
    estop = 1'b0;
    clr_fault = 1'b0;
    chk("t4_clr_with_estop", 32'(cmd_ready), 32'd0);
    pulse_clr();
    chk("t4_ready_back", 32'(cmd_ready), 32'd1);

    // 5: watchdog expiry after 100 RUN cycles
    push_cmd(8'd1, 8'd60, 8'd61);
    push_cmd(8'd1, 8'd62, 8'd63);
    exp_q.delete();
    wait_run(n);
    chk("t5_level_run", 32'(fifo_level), 32'd1);
    n = 1;
    while (gen_rst === 1'b0 && n < 300) begin
      @(negedge clk);
      if (gen_rst === 1'b0) n++;
    end
    chk("t5_run_cycles", 32'(n), 32'd100);
    chk("t5_timeout", 32'(timeout), 32'd1);
    chk("t5_flush", 32'(fifo_level), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready_blk", 32'(cmd_ready), 32'd0);
    pulse_clr();
    chk("t5_timeout_clr", 32'(timeout), 32'd0);
    chk("t5_ready_back", 32'(cmd_ready), 32'd1);

    // 6: abort beats gen_stop; then sync reset mid-RUN
    push_cmd(8'd1, 8'd70, 8'd80);
    wait_run(n);
    gen_stop = 1'b1;
    estop = 1'b1;
    exp_q.delete();
    @(negedge clk);
    gen_stop = 1'b0;
    estop = 1'b0;
    chk("t6_no_done", 32'(cmd_done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t6_no_done_late", 32'(cmd_done), 32'd0);
    pulse_clr();
    push_cmd(8'd9, 8'd0, 8'd0);
    push_cmd(8'd1, 8'd90, 8'd91);
    push_cmd(8'd1, 8'd92, 8'd93);
    wait_run(n);
    chk("t6_pre_rst_para2", 32'(gen_para2), 32'd90);
    chk("t6_pre_rst_err", 32'(err_type), 32'd1);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_post_rst_busy", 32'(busy), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
